// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-flow types: state encoding, BCD score type, event flag indices
package game_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE        = 3'd0,
        PLAYING     = 3'd1,
        HIT_FREEZE  = 3'd2,
        LEVEL_CLEAR = 3'd3,
        GAME_OVER   = 3'd4
    } state_t;

    typedef logic [15:0] bcd16_t;

    localparam bcd16_t BCD_MAX = 16'h9999;

    // Bit positions inside the per-frame sticky event vector
    localparam int EV_ROCKETS = 0;
    localparam int EV_ALIEN   = 1;
    localparam int EV_BODY    = 2;
    localparam int EV_SHOT    = 3;
    localparam int EV_BORDER  = 4;
    localparam int EV_W       = 5;
endpackage

// File: rtl/bcd_score_adder.sv
// rtl/bcd_score_adder.sv - combinational 4-digit BCD adder, saturating at 9999
module bcd_score_adder
    import game_pkg::*;
(
    input  bcd16_t a,
    input  bcd16_t b,
    output bcd16_t sum
);
    logic [4:0] digitSum;
    logic       carry;
    bcd16_t     rawSum;

    always_comb begin
        digitSum = '0;
        carry    = 1'b0;
        rawSum   = '0;
        for (int i = 0; i < 4; i++) begin
            digitSum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
            if (digitSum > 5'd9) begin
                digitSum = digitSum + 5'd6;
                carry    = 1'b1;
            end else begin
                carry    = 1'b0;
            end
            rawSum[4*i +: 4] = digitSum[3:0];
        end
        sum = carry ? BCD_MAX : rawSum;
    end
endmodule

// File: rtl/game_flow_manager.sv
// rtl/game_flow_manager.sv - frame-resolved game FSM: score, lives, level, freeze and respawn pulses
module game_flow_manager
    import game_pkg::*;
#(
    parameter int     START_LIVES       = 3,
    parameter int     NUM_ALIENS        = 32,
    parameter bcd16_t ALIEN_POINTS      = 16'h0010,
    parameter bcd16_t ROCKET_POINTS     = 16'h0005,
    parameter int     HIT_FREEZE_FRAMES = 60,
    parameter int     CLEAR_FRAMES      = 90
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               startKey,
    input  logic               alienHitPulse,
    input  logic               playerHitByAlienPulse,
    input  logic               playerHitByRocketPulse,
    input  logic               rocketsCollisionPulse,
    input  logic               aliensReachedBorder,
    output logic [STATE_W-1:0] gameState,
    output logic [15:0]        scoreBCD,
    output logic [2:0]         lives,
    output logic [3:0]         level,
    output logic               freeze,
    output logic               clearPlayerRocket,
    output logic               clearAlienRocket,
    output logic               levelStartPulse
);
    state_t          state;
    logic [EV_W-1:0] flags;
    logic [EV_W-1:0] evPulses;
    logic [7:0]      kills;
    logic [7:0]      killsNext;
    logic [7:0]      frameCnt;
    bcd16_t          rocketInc;
    bcd16_t          alienInc;
    bcd16_t          pointsInc;
    bcd16_t          scoreSum;
    logic            fatalHit;

    assign gameState = state;

    assign evPulses = {aliensReachedBorder, playerHitByRocketPulse, playerHitByAlienPulse,
                       alienHitPulse, rocketsCollisionPulse};

    // Both frame credits are summed first so one registered add covers the whole frame
    assign rocketInc = flags[EV_ROCKETS] ? ROCKET_POINTS : '0;
    assign alienInc  = flags[EV_ALIEN]   ? ALIEN_POINTS  : '0;

    bcd_score_adder incAdder (
        .a   (rocketInc),
        .b   (alienInc),
        .sum (pointsInc)
    );

    bcd_score_adder scoreAdder (
        .a   (scoreBCD),
        .b   (pointsInc),
        .sum (scoreSum)
    );

    assign killsNext = kills + {7'd0, flags[EV_ALIEN]};
    assign fatalHit  = flags[EV_BORDER] | flags[EV_BODY];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state             <= IDLE;
            scoreBCD          <= '0;
            lives             <= 3'(START_LIVES);
            level             <= 4'd1;
            freeze            <= 1'b1;
            clearPlayerRocket <= 1'b0;
            clearAlienRocket  <= 1'b0;
            levelStartPulse   <= 1'b0;
            flags             <= '0;
            kills             <= '0;
            frameCnt          <= '0;
        end else begin
            clearPlayerRocket <= 1'b0;
            clearAlienRocket  <= 1'b0;
            levelStartPulse   <= 1'b0;

            // A pulse on the frame boundary itself belongs to the frame that starts here
            if (startOfFrame) flags <= evPulses;
            else              flags <= flags | evPulses;

            case (state)
                IDLE: begin
                    if (startKey) begin
                        state           <= PLAYING;
                        freeze          <= 1'b0;
                        scoreBCD        <= '0;
                        lives           <= 3'(START_LIVES);
                        level           <= 4'd1;
                        kills           <= '0;
                        flags           <= '0;
                        levelStartPulse <= 1'b1;
                    end
                end
                PLAYING: begin
                    if (startOfFrame) begin
                        scoreBCD          <= scoreSum;
                        kills             <= killsNext;
                        clearPlayerRocket <= flags[EV_ROCKETS] | flags[EV_ALIEN];
                        clearAlienRocket  <= flags[EV_ROCKETS] | (flags[EV_SHOT] & ~fatalHit);
                        if (fatalHit) begin
                            lives  <= 3'd0;
                            state  <= GAME_OVER;
                            freeze <= 1'b1;
                        end else if (flags[EV_SHOT]) begin
                            freeze <= 1'b1;
                            if (lives == 3'd1) begin
                                lives <= 3'd0;
                                state <= GAME_OVER;
                            end else begin
                                lives    <= lives - 3'd1;
                                state    <= HIT_FREEZE;
                                frameCnt <= 8'(HIT_FREEZE_FRAMES);
                            end
                        end else if (killsNext == 8'(NUM_ALIENS)) begin
                            state    <= LEVEL_CLEAR;
                            freeze   <= 1'b1;
                            frameCnt <= 8'(CLEAR_FRAMES);
                        end
                    end
                end
                HIT_FREEZE, LEVEL_CLEAR: begin
                    if (startOfFrame) begin
                        if (frameCnt == 8'd1) begin
                            state  <= PLAYING;
                            freeze <= 1'b0;
                            if (state == LEVEL_CLEAR) begin
                                kills           <= '0;
                                level           <= (level == 4'd15) ? 4'd1 : level + 4'd1;
                                levelStartPulse <= 1'b1;
                            end
                        end else begin
                            frameCnt <= frameCnt - 8'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (startKey) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    freeze <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_flow_manager.sv
// tb/tb_game_flow_manager.sv - randomized self-checking bench for game_flow_manager
module tb_game_flow_manager;
    import game_pkg::*;

    localparam int START_LIVES = 3;
    localparam int NUM_ALIENS  = 2;
    localparam int HIT_FRAMES  = 60;
    localparam int CLR_FRAMES  = 4;
    localparam int ALIEN_DEC   = 10;
    localparam int ROCKET_DEC  = 5;
    localparam int FRAME_LEN   = 4;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               startKey = 1'b0;
    logic               alienHitPulse = 1'b0;
    logic               playerHitByAlienPulse = 1'b0;
    logic               playerHitByRocketPulse = 1'b0;
    logic               rocketsCollisionPulse = 1'b0;
    logic               aliensReachedBorder = 1'b0;
    logic [STATE_W-1:0] gameState;
    logic [15:0]        scoreBCD;
    logic [2:0]         lives;
    logic [3:0]         level;
    logic               freeze;
    logic               clearPlayerRocket;
    logic               clearAlienRocket;
    logic               levelStartPulse;

    game_flow_manager #(
        .START_LIVES       (START_LIVES),
        .NUM_ALIENS        (NUM_ALIENS),
        .ALIEN_POINTS      (16'h0010),
        .ROCKET_POINTS     (16'h0005),
        .HIT_FREEZE_FRAMES (HIT_FRAMES),
        .CLEAR_FRAMES      (CLR_FRAMES)
    ) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .startKey               (startKey),
        .alienHitPulse          (alienHitPulse),
        .playerHitByAlienPulse  (playerHitByAlienPulse),
        .playerHitByRocketPulse (playerHitByRocketPulse),
        .rocketsCollisionPulse  (rocketsCollisionPulse),
        .aliensReachedBorder    (aliensReachedBorder),
        .gameState              (gameState),
        .scoreBCD               (scoreBCD),
        .lives                  (lives),
        .level                  (level),
        .freeze                 (freeze),
        .clearPlayerRocket      (clearPlayerRocket),
        .clearAlienRocket       (clearAlienRocket),
        .levelStartPulse        (levelStartPulse)
    );

    always #5 clk = ~clk;

    // Event vector order used throughout the bench: {border, shot, body, alienHit, rockets}
    localparam logic [4:0] E_RC  = 5'b00001;
    localparam logic [4:0] E_AH  = 5'b00010;
    localparam logic [4:0] E_HBA = 5'b00100;
    localparam logic [4:0] E_HBR = 5'b01000;
    localparam logic [4:0] E_BRD = 5'b10000;

    int nChecks = 0;
    int nErrors = 0;

    int seenCpr = 0, seenCar = 0, seenLsp = 0;

    state_t     mState;
    int         mScore, mLives, mLevel, mKills, mFrames;
    logic [4:0] mFlags;
    int         eCpr = 0, eCar = 0, eLsp = 0;

    task automatic checkVal(input string tag, input int got, input int exp);
        nChecks++;
        if (got != exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int toBcd(input int v);
        return ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    task automatic modelReset();
        mState = IDLE; mScore = 0; mLives = START_LIVES; mLevel = 1;
        mKills = 0; mFrames = 0; mFlags = '0;
    endtask

    // Game rules applied to the inputs presented for one clock cycle
    task automatic modelStep(input bit sof, input logic [4:0] ev, input bit sk);
        logic [4:0] f;
        int inc;
        if (sof) begin f = mFlags; mFlags = ev; end
        else     begin f = '0;     mFlags = mFlags | ev; end
        if (mState == IDLE && sk) begin
            mState = PLAYING; mScore = 0; mLives = START_LIVES; mLevel = 1;
            mKills = 0; mFlags = '0; eLsp++;
        end else if (mState == GAME_OVER && sk) begin
            mState = IDLE;
        end else if (sof && mState == PLAYING) begin
            inc = 0;
            if (f[0]) inc += ROCKET_DEC;
            if (f[1]) begin inc += ALIEN_DEC; mKills++; end
            mScore = (mScore + inc > 9999) ? 9999 : mScore + inc;
            if (f[0] || f[1]) eCpr++;
            if (f[0] || (f[3] && !(f[2] || f[4]))) eCar++;
            if (f[2] || f[4]) begin
                mLives = 0; mState = GAME_OVER;
            end else if (f[3]) begin
                mLives--;
                if (mLives == 0) mState = GAME_OVER;
                else begin mState = HIT_FREEZE; mFrames = HIT_FRAMES; end
            end else if (mKills == NUM_ALIENS) begin
                mState = LEVEL_CLEAR; mFrames = CLR_FRAMES;
            end
        end else if (sof && (mState == HIT_FREEZE || mState == LEVEL_CLEAR)) begin
            mFrames--;
            if (mFrames == 0) begin
                if (mState == LEVEL_CLEAR) begin
                    mKills = 0; mLevel = mLevel % 15 + 1; eLsp++;
                end
                mState = PLAYING;
            end
        end
    endtask

    task automatic tick(input bit sof, input logic [4:0] ev, input bit sk);
        @(negedge clk);
        seenCpr += int'(clearPlayerRocket);
        seenCar += int'(clearAlienRocket);
        seenLsp += int'(levelStartPulse);
        startOfFrame           = sof;
        rocketsCollisionPulse  = ev[0];
        alienHitPulse          = ev[1];
        playerHitByAlienPulse  = ev[2];
        playerHitByRocketPulse = ev[3];
        aliensReachedBorder    = ev[4];
        startKey               = sk;
        modelStep(sof, ev, sk);
    endtask

    task automatic checkAll(input string tag);
        checkVal({tag, "_state"}, int'(gameState), int'(mState));
        checkVal({tag, "_score"}, int'(scoreBCD), toBcd(mScore));
        checkVal({tag, "_lives"}, int'(lives), mLives);
        checkVal({tag, "_level"}, int'(level), mLevel);
        checkVal({tag, "_freeze"}, int'(freeze), int'(mState != PLAYING));
        checkVal({tag, "_cpr"}, seenCpr, eCpr);
        checkVal({tag, "_car"}, seenCar, eCar);
        checkVal({tag, "_lsp"}, seenLsp, eLsp);
    endtask

    task automatic runFrame(input string tag, input logic [4:0] ev, input logic [4:0] co, input bit sk);
        for (int c = 0; c < FRAME_LEN - 1; c++)
            tick(1'b0, (c == 0) ? ev : (ev & 5'($urandom)), (c == 1) ? sk : 1'b0);
        tick(1'b1, co, 1'b0);
        tick(1'b0, '0, 1'b0);
        checkAll(tag);
    endtask

    task automatic pressStart(input string tag);
        tick(1'b0, '0, 1'b1);
        tick(1'b0, '0, 1'b0);
        checkAll(tag);
    endtask

    function automatic logic [4:0] randEv();
        logic [4:0] e;
        e[0] = ($urandom_range(0, 3) == 0);
        e[1] = ($urandom_range(0, 2) == 0);
        e[2] = ($urandom_range(0, 15) == 0);
        e[3] = ($urandom_range(0, 7) == 0);
        e[4] = ($urandom_range(0, 31) == 0);
        return e;
    endfunction

    initial begin
        int satFrames;
        modelReset();

        tick(1'b0, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        checkAll("reset");
        resetN = 1'b1;

        pressStart("start");
        runFrame("t1", '0, '0, 1'b0);
        checkVal("t1_playing", int'(gameState), int'(PLAYING));

        tick(1'b0, E_AH, 1'b0);
        tick(1'b0, '0, 1'b0);
        tick(1'b0, E_AH, 1'b0);
        tick(1'b0, E_AH, 1'b0);
        tick(1'b1, '0, 1'b0);
        tick(1'b0, '0, 1'b0);
        checkAll("t2");
        checkVal("t2_score", int'(scoreBCD), 16'h0010);

        runFrame("t3_hit", E_HBR, '0, 1'b0);
        checkVal("t3_lives", int'(lives), 2);
        for (int i = 0; i < HIT_FRAMES - 1; i++)
            runFrame("t3_frz", randEv(), '0, 1'($urandom_range(0, 1)));
        checkVal("t3_still_frozen", int'(gameState), int'(HIT_FREEZE));
        runFrame("t3_end", '0, '0, 1'b0);
        checkVal("t3_resume", int'(gameState), int'(PLAYING));

        runFrame("t4", E_AH | E_HBA, '0, 1'b0);
        checkVal("t4_score", int'(scoreBCD), 16'h0020);
        checkVal("t4_over", int'(gameState), int'(GAME_OVER));
        pressStart("t4_idle");
        checkVal("t4_idle_state", int'(gameState), int'(IDLE));

        pressStart("t6_start");
        runFrame("t6_coinc", '0, E_AH, 1'b0);
        checkVal("t6_not_yet", int'(scoreBCD), 16'h0000);
        runFrame("t6_next", '0, '0, 1'b0);
        checkVal("t6_counted", int'(scoreBCD), 16'h0010);

        runFrame("t5_die", E_BRD, '0, 1'b0);
        pressStart("t5_idle");
        pressStart("t5_start");
        runFrame("t5_k1", E_AH, '0, 1'b0);
        runFrame("t5_k2", E_AH, '0, 1'b0);
        checkVal("t5_clear", int'(gameState), int'(LEVEL_CLEAR));
        for (int i = 0; i < CLR_FRAMES; i++)
            runFrame("t5_wait", E_AH, '0, 1'b0);
        checkVal("t5_level", int'(level), 2);

        satFrames = 0;
        for (int i = 0; i < 4000 && satFrames < 3; i++) begin
            runFrame("grind", E_AH | 5'($urandom_range(0, 1)), '0, 1'b0);
            if (mScore == 9999) satFrames++;
        end
        checkVal("t5_saturated", int'(scoreBCD), 16'h9999);

        for (int i = 0; i < 10 && mState != PLAYING; i++)
            runFrame("to_play", '0, '0, 1'b0);
        checkVal("t6_reach_play", int'(gameState), int'(PLAYING));
        runFrame("t6_hit", E_HBR, '0, 1'b0);
        for (int i = 0; i < 5; i++)
            runFrame("t6_frz", '0, '0, 1'b0);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        checkVal("rst_state", int'(gameState), int'(IDLE));
        checkVal("rst_score", int'(scoreBCD), 0);
        checkVal("rst_lives", int'(lives), START_LIVES);
        checkVal("rst_level", int'(level), 1);
        checkVal("rst_freeze", int'(freeze), 1);
        checkVal("rst_pulses", int'({clearPlayerRocket, clearAlienRocket, levelStartPulse}), 0);
        modelReset();
        #2;
        resetN = 1'b1;

        for (int i = 0; i < 300; i++) begin
            bit sk;
            sk = (mState == IDLE || mState == GAME_OVER) ? 1'($urandom_range(0, 1))
                                                          : ($urandom_range(0, 9) == 0);
            runFrame("rand", randEv(), ($urandom_range(0, 7) == 0) ? randEv() : 5'd0, sk);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
